// File: rtl/pwls_reg_write_scheduler_pkg.sv
// Shared definitions for the PWL synth register write scheduler.
//   REG_BITS        - width of one ALU-unit register
//   CHAN_REG_STRIDE - registers per channel; channel index is addr[5:3]
//   reg_write_t     - one buffered host write (address + data)
package pwls_reg_write_scheduler_pkg;

   localparam int REG_BITS        = 16;
   localparam int CHAN_REG_STRIDE = 8;
   localparam int ADDR_BITS       = 6;

   typedef struct packed {
      logic [ADDR_BITS-1:0] addr;
      logic [REG_BITS-1:0]  data;
   } reg_write_t;

   // Channel index of a channel-register address (stride of 8 registers).
   function automatic logic [2:0] addr_chan(input logic [ADDR_BITS-1:0] addr);
      return addr[5:3];
   endfunction

endpackage

// File: rtl/pwls_reg_fifo.sv
// Synchronous FIFO buffering host register writes.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset (empties the FIFO)
//   push, din    - write request and data (ignored when full)
//   pop          - drop the head entry (ignored when empty)
//   dout         - head entry, valid while !empty
//   full, empty  - occupancy flags, derived from registered count only
module pwls_reg_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push_ok;
   logic             pop_ok;

   // Full is taken from the registered count, so a pop in the same cycle
   // never makes room for a push while full.
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/pwls_reg_write_scheduler.sv
// Schedules host register writes onto the time-sliced ALU unit.
// Channel registers are written only outside their owner's slot; global
// registers only on the frame boundary cycle.
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   en                       - advances slot timing and allows write issue
//   host_waddr/wdata/valid   - host write request
//   host_ready               - FIFO not full
//   reg_waddr/wdata/we       - registered write port to the ALU register file
//   cur_chan, slot_phase     - current slot owner and cycle within slot
//   frame_strobe             - last cycle of the last channel slot (while en)
module pwls_reg_write_scheduler
   import pwls_reg_write_scheduler_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int SLOT_CYCLES  = 8,
   parameter int FIFO_DEPTH   = 4,
   localparam int CHAN_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int PHASE_W = $clog2(SLOT_CYCLES)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [5:0]          host_waddr,
   input  logic [REG_BITS-1:0] host_wdata,
   input  logic                host_valid,
   output logic                host_ready,
   output logic [5:0]          reg_waddr,
   output logic [REG_BITS-1:0] reg_wdata,
   output logic                reg_we,
   output logic [CHAN_W-1:0]   cur_chan,
   output logic [PHASE_W-1:0]  slot_phase,
   output logic                frame_strobe
);

   reg_write_t push_entry;
   reg_write_t head_entry;
   logic       fifo_full;
   logic       fifo_empty;
   logic       accept;
   logic       issue;
   logic       last_phase;
   logic       last_chan;
   logic       head_is_chan;
   logic       head_chan_busy;

   assign host_ready = !fifo_full;
   assign accept     = host_valid && host_ready;
   assign push_entry = '{addr: host_waddr, data: host_wdata};

   pwls_reg_fifo #(
      .WIDTH ($bits(reg_write_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .pop   (issue),
      .din   (push_entry),
      .dout  (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Slot timing
   assign last_phase   = (slot_phase == PHASE_W'(SLOT_CYCLES - 1));
   assign last_chan    = (cur_chan == CHAN_W'(NUM_CHANNELS - 1));
   assign frame_strobe = en && last_phase && last_chan;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_phase <= '0;
         cur_chan   <= '0;
      end else if (en) begin
         if (last_phase) begin
            slot_phase <= '0;
            cur_chan   <= last_chan ? '0 : cur_chan + CHAN_W'(1);
         end else begin
            slot_phase <= slot_phase + PHASE_W'(1);
         end
      end
   end

   // Address classification and issue decision on the FIFO head
   assign head_is_chan   = (head_entry.addr < 6'(CHAN_REG_STRIDE * NUM_CHANNELS));
   assign head_chan_busy = (addr_chan(head_entry.addr) == 3'(cur_chan));

   always_comb begin
      issue = 1'b0;
      if (en && !fifo_empty) begin
         if (head_is_chan)
            issue = !head_chan_busy;
         else
            issue = frame_strobe;
      end
   end

   // Registered write port; address/data hold their last issued values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_we    <= 1'b0;
         reg_waddr <= '0;
         reg_wdata <= '0;
      end else begin
         reg_we <= issue;
         if (issue) begin
            reg_waddr <= head_entry.addr;
            reg_wdata <= head_entry.data;
         end
      end
   end

endmodule

// File: doc/pwls_reg_write_scheduler.md
PWLS_REG_WRITE_SCHEDULER -- requirements
Module: pwls_reg_write_scheduler

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of synth channels time-sliced on the shared ALU unit.
REQ-002 SHALL have parameter SLOT_CYCLES, default 8, ALU cycles per channel slot (power of two, >=2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, host write buffer entries (power of two).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  advances slot timing when high; freezes timing and write issue when low.
REQ-007 SHALL have port host_waddr  input  6  register address from host.
REQ-008 SHALL have port host_wdata  input  REG_BITS  register data from host.
REQ-009 SHALL have port host_valid  input  1  host write request.
REQ-010 SHALL have port host_ready  output  1  high when the FIFO is not full.
REQ-011 SHALL have port reg_waddr  output  6  address to the ALU unit register file.
REQ-012 SHALL have port reg_wdata  output  REG_BITS  data to the ALU unit register file.
REQ-013 SHALL have port reg_we  output  1  one-cycle write strobe to the ALU unit.
REQ-014 SHALL have port cur_chan  output  clog2(NUM_CHANNELS)  channel owning the current slot.
REQ-015 SHALL have port slot_phase  output  clog2(SLOT_CYCLES)  cycle index within the slot.
REQ-016 SHALL have port frame_strobe  output  1  high for one cycle on the last cycle of the last channel slot.

Function
REQ-017 SHALL accept a host write when host_valid && host_ready; the handshake is independent of en.
REQ-018 SHALL store accepted writes in order; issue strictly in order, head-of-line blocking allowed.
REQ-019 SHALL classify addresses: addr < 8*NUM_CHANNELS is channel register, channel = addr[5:3]; otherwise global register.
REQ-020 SHALL issue a channel-register head entry only in a cycle with en=1 and cur_chan != target channel.
REQ-021 SHALL issue a global-register head entry only in a cycle with en=1 and frame_strobe=1.
REQ-022 SHALL issue at most one write per cycle; reg_we, reg_waddr, reg_wdata registered, asserted the cycle after the issue decision (latency: accept to reg_we >= 2 cycles).
REQ-023 SHALL hold reg_waddr/reg_wdata at last issued values when reg_we=0.
REQ-024 SHALL increment slot_phase when en=1, wrapping at SLOT_CYCLES-1 and then incrementing cur_chan, wrapping at NUM_CHANNELS-1.
REQ-025 SHALL drive host_ready low exactly when FIFO holds FIFO_DEPTH entries; a same-cycle issue does not free space for a same-cycle accept when full.
REQ-026 SHALL support simultaneous accept and issue when not full and not empty; occupancy unchanged.
REQ-027 SHALL, when FIFO is empty, accept a write in cycle N and evaluate it for issue at the earliest in cycle N+1.
REQ-028 SHALL leave timing counters and FIFO contents unchanged while en=0; pending writes are not dropped.

Reset
REQ-029 SHALL, on reset assertion, immediately clear: FIFO empty, host_ready=1, reg_we=0, reg_waddr=0, reg_wdata=0, cur_chan=0, slot_phase=0, frame_strobe=0.
REQ-030 SHALL discard buffered and in-flight writes on reset; no reg_we after reset release until a new accept.
REQ-031 SHALL resume slot timing from channel 0, phase 0 on the first enabled cycle after reset release.

Structure
REQ-032 SHALL take REG_BITS and the per-channel register stride (8) from the shared pwl_synth package/header.
REQ-033 SHALL implement the buffer as sub-module pwls_reg_fifo (parameterised width/depth, push/pop/full/empty).
REQ-034 SHALL keep slot timing, address classification and issue logic in the top module.

Verification
REQ-035 SHALL cover: reset, en=1, no writes -> cur_chan 0,0..(8 cycles),1,...; frame_strobe once every 32 cycles at chan 3 phase 7.
REQ-036 SHALL cover: write addr 0x09 (chan 1) while cur_chan=1 -> reg_we held off until chan 2 slot, then one pulse with addr 0x09.
REQ-037 SHALL cover: write addr 0x25 (global) mid-frame -> reg_we exactly the cycle after frame_strobe.
REQ-038 SHALL cover: 5 back-to-back writes to chan 0 during chan 0 slot -> host_ready low after 4th, 5th accepted after first issue, all issued in order.
REQ-039 SHALL cover: en=0 for 10 cycles with 2 pending writes -> no reg_we, counters frozen; both issue after en returns.
REQ-040 SHALL cover: reset asserted with 3 pending writes -> outputs cleared asynchronously, no reg_we after release.
